// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the CPU control path: instruction fields, ALU/shift codes, FSM states.
// The register file and datapath import the same ALUop constants.
package cpu_defs;

    localparam int WORD_W = 16;
    localparam int REG_AW = 3;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_DECODE,
        ST_GET_A,
        ST_GET_B,
        ST_CALC,
        ST_CALC_S,
        ST_WRITE_REG,
        ST_WRITE_IMM
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_MVN,
        CLS_ARITH,      // ADD or AND: both operands read, result written back
        CLS_CMP
    } instr_cls_t;

    typedef struct packed {
        logic              w;
        logic [REG_AW-1:0] readnum;
        logic [REG_AW-1:0] writenum;
        logic              write;
        logic              loada;
        logic              loadb;
        logic              loadc;
        logic              loads;
        logic              asel;
        logic              bsel;
        logic              vsel;
        logic [1:0]        shift;
        logic [1:0]        alu_op;
    } ctrl_t;

    function automatic logic [WORD_W-1:0] sign_extend8(input logic [7:0] imm8);
        return {{(WORD_W - 8){imm8[7]}}, imm8};
    endfunction

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction field extractor and classifier for the 16-bit ISA subset.
module instr_dec
    import cpu_defs::*;
(
    input  logic [WORD_W-1:0] ir,
    output logic [1:0]        op,
    output logic [REG_AW-1:0] rn,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rm,
    output logic [1:0]        sh,
    output logic [WORD_W-1:0] sximm8,
    output instr_cls_t        cls
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = sign_extend8(ir[7:0]);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)
                    cls = CLS_MOV_IMM;
                else if (op == OP_MOV_REG)
                    cls = CLS_MOV_REG;
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD, OP_AND: cls = CLS_ARITH;
                    OP_CMP:         cls = CLS_CMP;
                    OP_MVN:         cls = CLS_MVN;
                    default:        cls = CLS_ILLEGAL;
                endcase
            end
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore control FSM sequencing one instruction per start pulse
// and driving the register file and datapath load/select strobes.
module cpu_controller
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] in,
    input  logic              load,
    input  logic              s,
    output logic              w,
    output logic [REG_AW-1:0] readnum,
    output logic [REG_AW-1:0] writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic              vsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [WORD_W-1:0] sximm8
);

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] ir;
    logic [1:0]        op;
    logic [1:0]        sh;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rm;
    instr_cls_t        cls;
    ctrl_t             ctrl;

    instr_dec u_dec (
        .ir     (ir),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .sximm8 (sximm8),
        .cls    (cls)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_WAIT;
        else
            state <= next_state;
    end

    // IR only accepts a new word while idle; a load and s in the same cycle decode the new word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ir <= '0;
        else if (load && state == ST_WAIT)
            ir <= in;
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            ST_WAIT: begin
                if (s)
                    next_state = ST_DECODE;
            end
            ST_DECODE: begin
                case (cls)
                    CLS_MOV_IMM:          next_state = ST_WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN: next_state = ST_GET_B;
                    CLS_ARITH, CLS_CMP:   next_state = ST_GET_A;
                    default:              next_state = ST_WAIT;
                endcase
            end
            ST_GET_A:     next_state = ST_GET_B;
            ST_GET_B:     next_state = (cls == CLS_CMP) ? ST_CALC_S : ST_CALC;
            ST_CALC:      next_state = ST_WRITE_REG;
            ST_CALC_S:    next_state = ST_WAIT;
            ST_WRITE_REG: next_state = ST_WAIT;
            ST_WRITE_IMM: next_state = ST_WAIT;
            default:      next_state = ST_WAIT;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            ST_WAIT: ctrl.w = 1'b1;
            ST_GET_A: begin
                ctrl.readnum = rn;
                ctrl.loada   = 1'b1;
            end
            ST_GET_B: begin
                ctrl.readnum = rm;
                ctrl.loadb   = 1'b1;
            end
            ST_CALC: begin
                ctrl.shift = sh;
                ctrl.loadc = 1'b1;
                // MOV register and MVN pass B through with A forced to zero.
                ctrl.asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
                case (cls)
                    CLS_MVN:   ctrl.alu_op = ALU_NOT;
                    CLS_ARITH: ctrl.alu_op = (op == OP_AND) ? ALU_AND : ALU_ADD;
                    default:   ctrl.alu_op = ALU_ADD;
                endcase
            end
            ST_CALC_S: begin
                ctrl.shift  = sh;
                ctrl.alu_op = ALU_SUB;
                ctrl.loads  = 1'b1;
            end
            ST_WRITE_REG: begin
                ctrl.writenum = rd;
                ctrl.write    = 1'b1;
                ctrl.vsel     = 1'b0;
            end
            ST_WRITE_IMM: begin
                ctrl.writenum = rn;
                ctrl.write    = 1'b1;
                ctrl.vsel     = 1'b1;
                ctrl.shift    = SH_NONE;
            end
            default: ctrl = '0;
        endcase
    end

    assign w        = ctrl.w;
    assign readnum  = ctrl.readnum;
    assign writenum = ctrl.writenum;
    assign write    = ctrl.write;
    assign loada    = ctrl.loada;
    assign loadb    = ctrl.loadb;
    assign loadc    = ctrl.loadc;
    assign loads    = ctrl.loads;
    assign asel     = ctrl.asel;
    assign bsel     = ctrl.bsel;
    assign vsel     = ctrl.vsel;
    assign shift    = ctrl.shift;
    assign ALUop    = ctrl.alu_op;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: per-cycle expected outputs are queued when an
// instruction is issued and compared on each falling edge while the queue is non-empty.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        load = 1'b0;
    logic        s = 1'b0;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        vsel;
    logic [1:0]  shift;
    logic [1:0]  alu_op;
    logic [15:0] sximm8;

    cpu_controller dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in),
        .load     (load),
        .s        (s),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (alu_op),
        .sximm8   (sximm8)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic        vsel;
        logic [1:0]  shift;
        logic [1:0]  alu_op;
        logic [15:0] sximm8;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  exp;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] prev_sx = 16'h0000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.w        = w;
        o.readnum  = readnum;
        o.writenum = writenum;
        o.write    = write;
        o.loada    = loada;
        o.loadb    = loadb;
        o.loadc    = loadc;
        o.loads    = loads;
        o.asel     = asel;
        o.bsel     = bsel;
        o.vsel     = vsel;
        o.shift    = shift;
        o.alu_op   = alu_op;
        o.sximm8   = sximm8;
        return o;
    endfunction

    function automatic obs_t o_none(input logic [15:0] sx);
        obs_t o = '0;
        o.sximm8 = sx;
        return o;
    endfunction

    function automatic obs_t o_idle(input logic [15:0] sx);
        obs_t o = o_none(sx);
        o.w = 1'b1;
        return o;
    endfunction

    function automatic obs_t o_get_a(input logic [15:0] sx, input logic [2:0] rn);
        obs_t o = o_none(sx);
        o.readnum = rn;
        o.loada   = 1'b1;
        return o;
    endfunction

    function automatic obs_t o_get_b(input logic [15:0] sx, input logic [2:0] rm);
        obs_t o = o_none(sx);
        o.readnum = rm;
        o.loadb   = 1'b1;
        return o;
    endfunction

    function automatic obs_t o_calc(input logic [15:0] sx, input logic [1:0] sh,
                                    input logic [1:0] aop, input logic a_zero);
        obs_t o = o_none(sx);
        o.shift  = sh;
        o.alu_op = aop;
        o.asel   = a_zero;
        o.loadc  = 1'b1;
        return o;
    endfunction

    function automatic obs_t o_write(input logic [15:0] sx, input logic [2:0] dst,
                                     input logic imm);
        obs_t o = o_none(sx);
        o.writenum = dst;
        o.write    = 1'b1;
        o.vsel     = imm;
        return o;
    endfunction

    task automatic push(input string tag, input obs_t o);
        exp_t e;
        e.tag = tag;
        e.exp = o;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.tag, sample(), e.exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present s (optionally with load in the same cycle); queue the idle cycle that sees s.
    task automatic start(input logic [15:0] word, input logic together, input logic [15:0] sx);
        step();
        in   = word;
        load = 1'b1;
        if (!together) begin
            step();
            load    = 1'b0;
            prev_sx = sx;
        end
        s = 1'b1;
        push("idle_s", o_idle(prev_sx));
        prev_sx = sx;
    endtask

    task automatic release_s();
        step();
        s    = 1'b0;
        load = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            check("timeout_drain", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        step();
    endtask

    task automatic push_add_a148();
        push("add_dec",   o_none(16'h0048));
        push("add_get_a", o_get_a(16'h0048, 3'd1));
        push("add_get_b", o_get_b(16'h0048, 3'd0));
        push("add_calc",  o_calc(16'h0048, 2'b01, 2'b00, 1'b0));
        push("add_write", o_write(16'h0048, 3'd2, 1'b0));
        push("add_done",  o_idle(16'h0048));
    endtask

    initial begin
        int wr_seen;

        // Reset with the clock running.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", sample(), o_idle(16'h0000));
        #2 reset_n = 1'b1;

        // MOV R0,#-2
        start(16'hD0FE, 1'b0, 16'hFFFE);
        push("movi_dec",   o_none(16'hFFFE));
        push("movi_write", o_write(16'hFFFE, 3'd0, 1'b1));
        push("movi_done",  o_idle(16'hFFFE));
        release_s();
        drain();

        // ADD R2,R1,R0 LSL#1
        start(16'hA148, 1'b0, 16'h0048);
        push_add_a148();
        release_s();
        drain();

        // CMP R3,R4
        start(16'hAB04, 1'b0, 16'h0004);
        begin
            obs_t o;
            push("cmp_dec",   o_none(16'h0004));
            push("cmp_get_a", o_get_a(16'h0004, 3'd3));
            push("cmp_get_b", o_get_b(16'h0004, 3'd4));
            o = o_none(16'h0004);
            o.alu_op = 2'b01;
            o.loads  = 1'b1;
            push("cmp_calc_s", o);
            push("cmp_done",   o_idle(16'h0004));
        end
        release_s();
        drain();

        // MVN R5,R6
        start(16'hB8A6, 1'b0, 16'hFFA6);
        push("mvn_dec",   o_none(16'hFFA6));
        push("mvn_get_b", o_get_b(16'hFFA6, 3'd6));
        push("mvn_calc",  o_calc(16'hFFA6, 2'b00, 2'b11, 1'b1));
        push("mvn_write", o_write(16'hFFA6, 3'd5, 1'b0));
        push("mvn_done",  o_idle(16'hFFA6));
        release_s();
        drain();

        // AND R1,R2,R3 ASR
        start(16'hB23B, 1'b0, 16'h003B);
        push("and_dec",   o_none(16'h003B));
        push("and_get_a", o_get_a(16'h003B, 3'd2));
        push("and_get_b", o_get_b(16'h003B, 3'd3));
        push("and_calc",  o_calc(16'h003B, 2'b11, 2'b10, 1'b0));
        push("and_write", o_write(16'h003B, 3'd1, 1'b0));
        push("and_done",  o_idle(16'h003B));
        release_s();
        drain();

        // MOV R7,R3 LSR with load and s together: decode must see the new word.
        start(16'hC0F3, 1'b1, 16'hFFF3);
        push("movr_dec",   o_none(16'hFFF3));
        push("movr_get_b", o_get_b(16'hFFF3, 3'd3));
        push("movr_calc",  o_calc(16'hFFF3, 2'b10, 2'b00, 1'b1));
        push("movr_write", o_write(16'hFFF3, 3'd7, 1'b0));
        push("movr_done",  o_idle(16'hFFF3));
        release_s();
        drain();

        // Illegal opcode: one DECODE cycle, no strobes, back to WAIT.
        start(16'hE000, 1'b0, 16'h0000);
        push("ill_dec",  o_none(16'h0000));
        push("ill_done", o_idle(16'h0000));
        release_s();
        drain();

        // load during GET_B of an ADD must leave IR untouched.
        start(16'hA148, 1'b0, 16'h0048);
        push_add_a148();
        release_s();
        step();
        step();
        in   = 16'hD0FE;
        load = 1'b1;
        step();
        load = 1'b0;
        drain();

        // Reset pulsed low during GET_B of an ADD.
        start(16'hA148, 1'b0, 16'h0048);
        push("rst_add_dec",   o_none(16'h0048));
        push("rst_add_get_a", o_get_a(16'h0048, 3'd1));
        push("rst_add_get_b", o_get_b(16'h0048, 3'd0));
        release_s();
        step();
        step();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("reset_mid_instr", sample(), o_idle(16'h0000));
        wr_seen = 0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (write)
                wr_seen++;
        end
        check("no_write_after_reset", 64'(wr_seen), 64'd0);
        @(negedge clk);
        check("idle_after_reset", sample(), o_idle(16'h0000));
        prev_sx = 16'h0000;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
